averager_accumulator: RTL and testbench
=======================================

// Module: averager_accumulator
// PURPOSE
//   Accumulates signed ADC samples into a double-buffered memory using the address/wen/init/ready
//   stream produced by the averager counter directly upstream.
//   Each wen beat does one read-modify-write: mem[address] += din, or mem[address] = din when init=1.
//   On ready, the completed bank is handed to the readout side (AXI/BRAM reader) and the next pass
//   accumulates into the other bank.
// PARAMETERS
//   DATA_WIDTH   14  signed sample width
//   ACC_WIDTH    32  accumulator word width (>= DATA_WIDTH)
//   ADDR_WIDTH    7  address width per bank (FAST_COUNT_WIDTH+2 of the counter); depth 2**ADDR_WIDTH
//   N_AVG_WIDTH  10  width of n_avg (SLOW_COUNT_WIDTH of the counter)
// PORTS
//   clk        in   1            clock; all logic rising-edge
//   rst        in   1            synchronous reset, active-high
//   din        in   DATA_WIDTH   signed sample, qualified by wen
//   wen        in   1            accumulate din at address this cycle
//   init       in   1            with wen: overwrite instead of add (first pass of an average)
//   ready      in   1            1-cycle pulse: current beat (if any) is the last of the average
//   address    in   ADDR_WIDTH   accumulation address
//   n_avg      in   N_AVG_WIDTH  number of passes accumulated, valid with ready
//   rd_addr    in   ADDR_WIDTH   readout address into the completed bank
//   rd_data    out  ACC_WIDTH    mem[rd_bank][rd_addr], 1-cycle latency
//   avg_valid  out  1            1-cycle pulse: completed bank switched, avg_n updated
//   avg_n      out  N_AVG_WIDTH  n_avg latched with the bank switch
//   overflow   out  1            sticky saturation flag for the current pass (see CONFIGURATION)
// BEHAVIOUR
//   Reset: wr_bank=0, rd_bank=1, pipeline valids=0, rd_data=0, avg_valid=0, avg_n=0, overflow=0.
//     Memory contents are not cleared; in-flight writes are dropped. rst mid-pass gives a
//     partial bank, which is not published.
//   Pipeline, 3 stages, one beat/cycle, no stall:
//     S0 (cycle t):   sample wen/init/ready/address/din, tag with wr_bank, issue read of mem[wr_bank][address].
//     S1 (t+1):       operand = forwarded value if a hit, else read data;
//                     sum = init ? sext(din) : operand + sext(din); registered.
//     S2 (t+2):       write sum to mem[tag][addr] at end of cycle.
//   Forwarding (compare valid && bank tag && address):
//     - The S2 pending write has priority.
//     - Next priority is the S3 register, which holds the write that retired in the previous cycle.
//     - Back-to-back and distance-2 beats to the same address must accumulate exactly.
//   Arithmetic: two's complement; din is sign-extended to ACC_WIDTH. Without SATURATE_EN the sum
//     wraps mod 2**ACC_WIDTH.
//   Bank switch:
//     - ready sampled at t toggles wr_bank at end of t; beats from t+1 go to the new bank.
//     - The ready tag travels with the beat. When it retires from S2 (end of t+2):
//       rd_bank <= old wr_bank, avg_n <= n_avg, avg_valid=1 during t+3, overflow cleared.
//     - ready with wen=0 still switches banks at the same timing.
//     - Two ready pulses 1-2 cycles apart are each honoured in order.
//   Readout: rd_data <= mem[rd_bank][rd_addr] every cycle. It is never affected by accumulation
//     writes, since they always target the other bank. rd_addr changing during avg_valid gives new-bank data.
//   wen=0 beats pass through as bubbles; no memory write.
// CONFIGURATION
//   SATURATE_EN defined:
//     - S1 sum clamps to [-2**(ACC_WIDTH-1), 2**(ACC_WIDTH-1)-1].
//     - overflow goes to 1 on any clamp and stays set until the bank switch or rst.
//   SATURATE_EN undefined: sum wraps; overflow tied 0.
// TESTING
//   1. rst, then one init pass: addresses 0..15, din=addr*3, ready on the last beat.
//      -> avg_valid at +3, rd_data[k]=3k, avg_n=n_avg.
//   2. Four passes of 16 beats, din=-100, init on the first pass, n_avg=4.
//      -> rd_data=-400 on all 16 addresses, single avg_valid.
//   3. Hazards: wen every cycle, address pattern 5,5,5,5 and 5,9,5,9, din=1, init on the first hit.
//      -> mem[5]=4 and mem[5]=mem[9]=2 respectively (S2/S3 forwarding).
//   4. Ping-pong: after pass A publishes, run pass B while sweeping rd_addr.
//      -> rd_data stays equal to pass A until B's avg_valid, then shows B.
//   5. ACC_WIDTH=16, din=8191, 5 passes.
//      -> SATURATE_EN: 32767 and overflow=1; without: wrapped -24581 and overflow=0.
//   6. rst asserted mid-pass at beat 7.
//      -> outputs at reset values next cycle, no avg_valid; a clean new pass then publishes correctly.

Source files
------------

// File: rtl/averager_accumulator.sv
// averager_accumulator: 3-stage read-modify-write accumulator, ping-pong banks.
// Optional SATURATE_EN: clamp sums, sticky overflow until bank switch.
module averager_accumulator #(
  parameter int DATA_WIDTH  = 14,
  parameter int ACC_WIDTH   = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int N_AVG_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   wen,
  input  logic                   init,
  input  logic                   ready,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic [N_AVG_WIDTH-1:0] n_avg,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [ACC_WIDTH-1:0]   rd_data,
  output logic                   avg_valid,
  output logic [N_AVG_WIDTH-1:0] avg_n,
  output logic                   overflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ACC_WIDTH-1:0] mem [0:2*DEPTH-1];
  logic [ACC_WIDTH-1:0] mem_rd_q;
  logic [ACC_WIDTH-1:0] rd_data_q;

  logic wr_bank_q, wr_bank_d;
  logic rd_bank_q, rd_bank_d;
  logic avg_valid_q, avg_valid_d;
  logic [N_AVG_WIDTH-1:0] avg_n_q, avg_n_d;

  logic s1_vld_q, s1_vld_d;
  logic s1_rdy_q, s1_rdy_d;
  logic s1_init_q, s1_init_d;
  logic s1_bank_q, s1_bank_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] s1_din_q, s1_din_d;
  logic [N_AVG_WIDTH-1:0] s1_navg_q, s1_navg_d;

  logic s2_vld_q, s2_vld_d;
  logic s2_rdy_q, s2_rdy_d;
  logic s2_bank_q, s2_bank_d;
  logic [ADDR_WIDTH-1:0] s2_addr_q, s2_addr_d;
  logic [ACC_WIDTH-1:0] s2_sum_q, s2_sum_d;
  logic [N_AVG_WIDTH-1:0] s2_navg_q, s2_navg_d;

  logic s3_vld_q, s3_vld_d;
  logic s3_bank_q, s3_bank_d;
  logic [ADDR_WIDTH-1:0] s3_addr_q, s3_addr_d;
  logic [ACC_WIDTH-1:0] s3_sum_q, s3_sum_d;

  logic hit2, hit3;
  logic [ACC_WIDTH-1:0] opnd, dext, sum;
  logic signed [DATA_WIDTH-1:0] din_s;

`ifdef SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic [ACC_WIDTH:0] wide;
  logic clamp;
  logic ovf_q, ovf_d;
`endif

  // S1: take the newest in-flight value for this address, then add or load
  always_comb begin
    hit2 = s2_vld_q && (s2_bank_q == s1_bank_q)
        && (s2_addr_q == s1_addr_q);
    hit3 = s3_vld_q && (s3_bank_q == s1_bank_q)
        && (s3_addr_q == s1_addr_q);
    opnd = mem_rd_q;
    if (hit2) begin
      opnd = s2_sum_q;
    end else if (hit3) begin
      opnd = s3_sum_q;
    end
    din_s = s1_din_q;
    dext = ACC_WIDTH'(din_s);
`ifdef SATURATE_EN
    clamp = 1'b0;
    wide = {opnd[ACC_WIDTH-1], opnd} + {dext[ACC_WIDTH-1], dext};
    sum = wide[ACC_WIDTH-1:0];
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1]) begin
      clamp = 1'b1;
      sum = wide[ACC_WIDTH] ? SMIN : SMAX;
    end
    if (s1_init_q) begin
      clamp = 1'b0;
      sum = dext;
    end
`else
    sum = s1_init_q ? dext : opnd + dext;
`endif
  end

  // Pipeline advance, bank toggling and publication of the completed bank
  always_comb begin
    wr_bank_d = wr_bank_q ^ ready;
    s1_vld_d  = wen;
    s1_rdy_d  = ready;
    s1_init_d = init;
    s1_bank_d = wr_bank_q;
    s1_addr_d = address;
    s1_din_d  = din;
    s1_navg_d = n_avg;
    s2_vld_d  = s1_vld_q;
    s2_rdy_d  = s1_rdy_q;
    s2_bank_d = s1_bank_q;
    s2_addr_d = s1_addr_q;
    s2_sum_d  = sum;
    s2_navg_d = s1_navg_q;
    s3_vld_d  = s2_vld_q;
    s3_bank_d = s2_bank_q;
    s3_addr_d = s2_addr_q;
    s3_sum_d  = s2_sum_q;
    rd_bank_d = rd_bank_q;
    avg_n_d   = avg_n_q;
    avg_valid_d = s2_rdy_q;
    if (s2_rdy_q) begin
      rd_bank_d = s2_bank_q;
      avg_n_d   = s2_navg_q;
    end
  end

  // State registers; in-flight beats are discarded on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b1;
      avg_valid_q <= 1'b0;
      avg_n_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_rdy_q    <= 1'b0;
      s1_init_q   <= 1'b0;
      s1_bank_q   <= 1'b0;
      s1_addr_q   <= '0;
      s1_din_q    <= '0;
      s1_navg_q   <= '0;
      s2_vld_q    <= 1'b0;
      s2_rdy_q    <= 1'b0;
      s2_bank_q   <= 1'b0;
      s2_addr_q   <= '0;
      s2_sum_q    <= '0;
      s2_navg_q   <= '0;
      s3_vld_q    <= 1'b0;
      s3_bank_q   <= 1'b0;
      s3_addr_q   <= '0;
      s3_sum_q    <= '0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      avg_valid_q <= avg_valid_d;
      avg_n_q     <= avg_n_d;
      s1_vld_q    <= s1_vld_d;
      s1_rdy_q    <= s1_rdy_d;
      s1_init_q   <= s1_init_d;
      s1_bank_q   <= s1_bank_d;
      s1_addr_q   <= s1_addr_d;
      s1_din_q    <= s1_din_d;
      s1_navg_q   <= s1_navg_d;
      s2_vld_q    <= s2_vld_d;
      s2_rdy_q    <= s2_rdy_d;
      s2_bank_q   <= s2_bank_d;
      s2_addr_q   <= s2_addr_d;
      s2_sum_q    <= s2_sum_d;
      s2_navg_q   <= s2_navg_d;
      s3_vld_q    <= s3_vld_d;
      s3_bank_q   <= s3_bank_d;
      s3_addr_q   <= s3_addr_d;
      s3_sum_q    <= s3_sum_d;
    end
  end

  // Bank memory: S2 write, S0 operand read (read sees pre-write data)
  always_ff @(posedge clk) begin
    if (s2_vld_q && !rst) begin
      mem[{s2_bank_q, s2_addr_q}] <= s2_sum_q;
    end
    mem_rd_q <= mem[{wr_bank_q, address}];
  end

  // Readout port on the published bank
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem[{rd_bank_q, rd_addr}];
    end
  end

`ifdef SATURATE_EN
  // Sticky clamp flag; a clamp in the new pass wins over the clear
  always_comb begin
    ovf_d = ovf_q;
    if (s2_rdy_q) begin
      ovf_d = 1'b0;
    end
    if (s1_vld_q && clamp) begin
      ovf_d = 1'b1;
    end
  end

  // Overflow register
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign rd_data   = rd_data_q;
  assign avg_valid = avg_valid_q;
  assign avg_n     = avg_n_q;
endmodule

// File: tb/tb_averager_accumulator.sv
// tb_averager_accumulator: directed scenarios plus random averages,
// checked every cycle against a sequential bank-memory model.
module tb_averager_accumulator;
  localparam int DW  = 14;
  localparam int AW  = 16;
  localparam int ADW = 7;
  localparam int NW  = 10;
  localparam int DEPTH = 1 << ADW;
  localparam longint SMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (AW - 1));

  typedef logic [AW-1:0] acc_t;

  typedef struct packed {
    logic v;
    logic init;
    logic rdy;
    logic bank;
    logic known;
    logic [ADW-1:0] addr;
    logic [DW-1:0] din;
    logic [NW-1:0] n;
    logic [AW-1:0] sum;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic wen = 1'b0;
  logic init = 1'b0;
  logic ready = 1'b0;
  logic [ADW-1:0] address = '0;
  logic [NW-1:0] n_avg = '0;
  logic [ADW-1:0] rd_addr = '0;
  logic [AW-1:0] rd_data;
  logic avg_valid;
  logic [NW-1:0] avg_n;
  logic overflow;

  int n_chk = 0;
  int n_fail = 0;

  averager_accumulator #(
    .DATA_WIDTH(DW), .ACC_WIDTH(AW),
    .ADDR_WIDTH(ADW), .N_AVG_WIDTH(NW)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .wen(wen),
    .init(init), .ready(ready), .address(address),
    .n_avg(n_avg), .rd_addr(rd_addr), .rd_data(rd_data),
    .avg_valid(avg_valid), .avg_n(avg_n), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ax(longint v);
    acc_t t;
    t = acc_t'(v);
    return 64'(t);
  endfunction

  // Reference: memory updated in beat order, outputs on their fixed delays
  acc_t mm [2][DEPTH];
  bit mk [2][DEPTH];
  beat_t p1, p2, nb;
  bit m_wr, m_rd, started;
  acc_t exp_rd;
  bit exp_rd_k, exp_valid, exp_ovf, clr, setf;
  logic [NW-1:0] exp_n;
  longint op, dv, r;

  always @(posedge clk) begin
    if (rst) begin
      p1 = '0;
      p2 = '0;
      m_wr = 1'b0;
      m_rd = 1'b1;
      exp_valid = 1'b0;
      exp_n = '0;
      exp_ovf = 1'b0;
      exp_rd = '0;
      exp_rd_k = 1'b1;
      started = 1'b1;
    end else begin
      exp_rd = mm[m_rd][rd_addr];
      exp_rd_k = mk[m_rd][rd_addr];
      exp_valid = 1'b0;
      clr = 1'b0;
      setf = 1'b0;
      if (p2.v) begin
        mm[p2.bank][p2.addr] = p2.sum;
        mk[p2.bank][p2.addr] = p2.known;
      end
      if (p2.rdy) begin
        m_rd = p2.bank;
        exp_n = p2.n;
        exp_valid = 1'b1;
        clr = 1'b1;
      end
      if (p1.v) begin
        op = longint'($signed(mm[p1.bank][p1.addr]));
        dv = longint'($signed(p1.din));
        r = p1.init ? dv : op + dv;
        p1.known = p1.init || mk[p1.bank][p1.addr];
`ifdef SATURATE_EN
        if (r > SMAX) begin
          r = SMAX;
          setf = p1.known;
        end else if (r < SMIN) begin
          r = SMIN;
          setf = p1.known;
        end
`endif
        p1.sum = acc_t'(r);
      end
`ifdef SATURATE_EN
      exp_ovf = (clr ? 1'b0 : exp_ovf) | setf;
`else
      exp_ovf = 1'b0;
`endif
      nb = '0;
      nb.v = wen;
      nb.init = init;
      nb.rdy = ready;
      nb.bank = m_wr;
      nb.addr = address;
      nb.din = din;
      nb.n = n_avg;
      p2 = p1;
      p1 = nb;
      if (ready) m_wr = !m_wr;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("avg_valid", 64'(avg_valid), 64'(exp_valid));
      chk("avg_n", 64'(avg_n), 64'(exp_n));
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      if (exp_rd_k) chk("rd_data", 64'(rd_data), 64'(exp_rd));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic beat(bit w, bit i, bit rd, int a, int d, int n);
    wen = w;
    init = i;
    ready = rd;
    address = ADW'(a);
    din = DW'(d);
    n_avg = NW'(n);
    step();
    wen = 1'b0;
    init = 1'b0;
    ready = 1'b0;
  endtask

  task automatic idle();
    wen = 1'b0;
    init = 1'b0;
    ready = 1'b0;
    step();
  endtask

  task automatic rb(string nm, int k, longint e);
    rd_addr = ADW'(k);
    step();
    chk(nm, 64'(rd_data), ax(e));
  endtask

  task automatic chk_reset(string nm);
    chk({nm, "_valid"}, 64'(avg_valid), 64'(0));
    chk({nm, "_n"}, 64'(avg_n), 64'(0));
    chk({nm, "_ovf"}, 64'(overflow), 64'(0));
    chk({nm, "_rd"}, 64'(rd_data), 64'(0));
  endtask

  initial begin
    @(negedge clk);
    step();
    rst = 1'b0;
    chk_reset("rst");

    // single init pass, din = 3*addr
    for (int k = 0; k < 16; k++) beat(1, 1, k == 15, k, 3 * k, 1);
    chk("t1_early", 64'(avg_valid), 64'(0));
    idle();
    idle();
    chk("t1_valid", 64'(avg_valid), 64'(1));
    chk("t1_n", 64'(avg_n), 64'(1));
    for (int k = 0; k < 16; k++) rb("t1_rd", k, 3 * k);

    // ping-pong: pass B accumulates while A is read out
    for (int k = 0; k < 16; k++) begin
      rd_addr = ADW'(k);
      beat(1, 1, k == 15, k, -(k + 1), 2);
      chk("pp_hold", 64'(rd_data), ax(3 * k));
    end
    rd_addr = 0;
    idle();
    chk("pp_t2", 64'(rd_data), ax(0));
    rd_addr = 2;
    idle();
    chk("pp_valid", 64'(avg_valid), 64'(1));
    chk("pp_t3", 64'(rd_data), ax(6));
    rd_addr = 1;
    idle();
    chk("pp_new", 64'(rd_data), ax(-2));
    for (int k = 0; k < 16; k++) rb("pp_b", k, -(k + 1));

    // four passes of -100
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 16; k++)
        beat(1, p == 0, p == 3 && k == 15, k, -100, 4);
    idle();
    idle();
    chk("t2_valid", 64'(avg_valid), 64'(1));
    chk("t2_n", 64'(avg_n), 64'(4));
    for (int k = 0; k < 16; k++) rb("t2_rd", k, -400);

    // hazards: distance 1 and distance 2
    for (int k = 0; k < 4; k++) beat(1, k == 0, k == 3, 5, 1, 4);
    idle();
    idle();
    rb("hz_d1", 5, 4);
    for (int k = 0; k < 4; k++)
      beat(1, k < 2, k == 3, (k % 2 == 0) ? 5 : 9, 1, 2);
    idle();
    idle();
    rb("hz_d2a", 5, 2);
    rb("hz_d2b", 9, 2);

    // five passes of 8191 into a 16-bit accumulator
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < 16; k++) begin
        beat(1, p == 0, p == 4 && k == 15, k, 8191, 5);
`ifdef SATURATE_EN
        if (p == 4 && k == 8) chk("sat_ovf", 64'(overflow), 64'(1));
`else
        if (p == 4 && k == 8) chk("wrap_ovf", 64'(overflow), 64'(0));
`endif
      end
    idle();
    idle();
    chk("t5_valid", 64'(avg_valid), 64'(1));
    chk("t5_ovf_clr", 64'(overflow), 64'(0));
`ifdef SATURATE_EN
    for (int k = 0; k < 16; k++) rb("t5_sat", k, 32767);
`else
    for (int k = 0; k < 16; k++) rb("t5_wrap", k, -24581);
`endif

    // reset mid-pass at beat 7
    for (int k = 0; k < 7; k++) beat(1, 1, 0, k, k + 7, 1);
    rst = 1'b1;
    beat(1, 0, 0, 7, 14, 1);
    rst = 1'b0;
    chk_reset("mid_rst");
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("mid_novalid", 64'(avg_valid), 64'(0));
    end
    for (int k = 0; k < 16; k++) beat(1, 1, k == 15, k, 5 * k - 20, 1);
    idle();
    idle();
    chk("t6_valid", 64'(avg_valid), 64'(1));
    for (int k = 0; k < 16; k++) rb("t6_rd", k, 5 * k - 20);

    // random averages, short ones give closely spaced ready pulses
    for (int a = 0; a < 40; a++) begin
      int np, len, nbts, n;
      bit seen [16];
      np = $urandom_range(1, 4);
      len = $urandom_range(1, 12);
      n = $urandom_range(0, 1023);
      for (int s = 0; s < 16; s++) seen[s] = 1'b0;
      if ($urandom_range(0, 4) == 0) np = 1;
      for (int p = 0; p < np; p++) begin
        nbts = (np == 1 && $urandom_range(0, 2) == 0) ? 1
             : $urandom_range(1, 2 * len);
        for (int b = 0; b < nbts; b++) begin
          bit w, i, last;
          int ad;
          w = ($urandom_range(0, 3) != 0);
          ad = $urandom_range(0, len - 1);
          last = (p == np - 1) && (b == nbts - 1);
          i = w && (!seen[ad] || $urandom_range(0, 19) == 0);
          if (w) seen[ad] = 1'b1;
          rd_addr = ADW'($urandom_range(0, 15));
          beat(w, i, last, ad, int'($urandom_range(0, 16383)), n);
        end
      end
    end
    for (int k = 0; k < 6; k++) idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
